bit_health_monitor: RTL
=======================

# bit_health_monitor

Sits directly downstream of `data_stream` and consumes its raw serial random-bit output. Runs continuous SP 800-90B style health tests on every bit: a Repetition Count Test (RCT) and an Adaptive Proportion Test (APT). Packs the healthy bits MSB-first into bytes on a valid/ready output. Any health failure latches an alarm and permanently stops byte output until reset.

## Interface
- `RCT_CUTOFF`, default 21: run length of identical bits that triggers RCT failure (2..255).
- `APT_WINDOW`, default 1024: APT window size in bits (power of two, 16..4096).
- `APT_CUTOFF`, default 589: count of reference-bit matches in one window that triggers APT failure (2..APT_WINDOW).
- `STARTUP_BITS`, default 1024: bits tested but not output after reset (1..65535).

- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  serial bit from `data_stream.data_out`.
- `bit_valid`  in  1  `bit_in` is accepted on any edge where this is high; no back-pressure to upstream.
- `byte_out`  out  8  packed byte, first received bit in bit 7.
- `byte_valid`  out  1  `byte_out` holds an unconsumed byte.
- `byte_ready`  in  1  consumer accepts `byte_out` on an edge where `byte_valid && byte_ready`.
- `rct_fail`  out  1  sticky RCT failure.
- `apt_fail`  out  1  sticky APT failure.
- `overflow`  out  1  sticky: a completed byte was dropped because the output register was full.
- `startup_done`  out  1  high once in RUN state.

## Operation
- Reset values: `byte_out`=0x00, `byte_valid`=0, `rct_fail`=0, `apt_fail`=0, `overflow`=0, `startup_done`=0; all counters 0; state STARTUP.
- States: STARTUP -> RUN when the STARTUP_BITS-th bit is accepted without failure. STARTUP or RUN -> FAIL on any failure. FAIL exits only via `rst`.
- RCT: first bit after reset sets run=1. Each later accepted bit: equal to previous -> run+1 (saturating at RCT_CUTOFF), else run=1. run reaching RCT_CUTOFF sets `rct_fail`.
- APT: first bit of a window is the reference; match=1, idx=1. Each later bit: idx+1; equal to reference -> match+1. match reaching APT_CUTOFF sets `apt_fail`. After idx reaches APT_WINDOW, the next accepted bit starts a new window. The first bit after reset starts a window.
- Health tests run in STARTUP, RUN and FAIL. Flags are sticky regardless.
- Packing in RUN only. The shift register starts empty at RUN entry. The first bit accepted in RUN goes to bit 7, the eighth to bit 0.
- On the eighth bit:
  - Output register empty, or being consumed on the same edge: load it and set `byte_valid`.
  - Otherwise: drop the new byte, set `overflow`, keep the held byte.
  - The packer restarts empty either way.
- FAIL: `byte_valid` clears on the failing edge, and a byte still held is discarded. The partial packer contents are discarded. No further bytes are produced.
- `bit_valid` low: no counter, packer or state change. `byte_valid` still clears on a handshake.

## Timing
- A bit accepted at edge N updates all counters and flags at edge N. Fail flags are visible in cycle N+1.
- A byte completed at edge N gives `byte_valid`=1 and `byte_out` valid from cycle N+1. Minimum byte latency is 8 accepted bits.
- Failure and byte completion on the same edge: the failure wins; no byte is emitted and `byte_valid`=0.
- `startup_done` rises at the same edge as the STARTUP->RUN transition.
- Sustained throughput: 1 byte per 8 cycles at `bit_valid`=1, provided the consumer accepts within 8 cycles.
- `rst` mid-byte or in FAIL: all state returns to reset values at that edge; the partial byte is lost.

## Test plan
- Alternating 0,1 stream with STARTUP_BITS=16: 16 bits give `startup_done`=1 and no bytes. The next bits 1,0,1,1,0,0,1,0 give `byte_out`=0xB2 and `byte_valid`=1 one cycle after the eighth bit. No fail flags.
- RCT boundary, defaults: 20 ones then a 0 -> no `rct_fail`. 21 consecutive ones -> `rct_fail`=1 after the 21st bit's edge, `byte_valid`=0, and no byte thereafter.
- APT with APT_WINDOW=16, APT_CUTOFF=10, RCT_CUTOFF=255:
  - A window with 9 matches -> no fail. The next window starts with a fresh reference.
  - A window with its 10th match at bit 12 -> `apt_fail`=1 at that edge.
- Back-pressure with `byte_ready`=0: the first byte 0xA5 is held. Sixteen further bits -> `overflow`=1 and `byte_out` stays 0xA5. Raising `byte_ready` clears `byte_valid` next edge.
- Simultaneous events: the RCT cutoff bit is also the eighth bit of a byte -> `rct_fail`=1 and no byte emitted.
- `bit_valid` gaps of random length within a byte -> same byte value as the gapless run.
- `rst` pulse in FAIL or mid-byte -> all outputs at reset values. Startup restarts and needs the full STARTUP_BITS.

Source files
------------

// File: rtl/bit_health_monitor.sv
// rtl/bit_health_monitor.sv - RCT/APT health tests on a raw bit stream, packs healthy bits MSB-first into bytes
`timescale 1ns/1ps
module bit_health_monitor #(
  parameter int RCT_CUTOFF   = 21,
  parameter int APT_WINDOW   = 1024,
  parameter int APT_CUTOFF   = 589,
  parameter int STARTUP_BITS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       rct_fail,
  output logic       apt_fail,
  output logic       overflow,
  output logic       startup_done
);

  typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAIL} state_e;

  localparam logic [7:0]  RCT_CUT = 8'(RCT_CUTOFF);
  localparam logic [12:0] APT_WIN = 13'(APT_WINDOW);
  localparam logic [12:0] APT_CUT = 13'(APT_CUTOFF);
  localparam logic [15:0] SU_BITS = 16'(STARTUP_BITS);

  state_e      state_q, state_d;
  logic        prev_q, prev_d;
  logic [7:0]  run_q, run_d;
  logic        ref_q, ref_d;
  logic [12:0] match_q, match_d;
  logic [12:0] idx_q, idx_d;
  logic [15:0] su_cnt_q, su_cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic [2:0]  pk_cnt_q, pk_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        rct_q, rct_d;
  logic        apt_q, apt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        fail_now;
  logic [7:0]  full_byte;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    ref_d     = ref_q;
    match_d   = match_q;
    idx_d     = idx_q;
    su_cnt_d  = su_cnt_q;
    sh_d      = sh_q;
    pk_cnt_d  = pk_cnt_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    rct_d     = rct_q;
    apt_d     = apt_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    fail_now  = 1'b0;
    full_byte = {sh_q, bit_in};

    if (valid_q && byte_ready) valid_d = 1'b0;

    if (bit_valid) begin
      // run_q == 0 marks "no bit seen since reset"
      if (run_q == 8'd0 || bit_in != prev_q) run_d = 8'd1;
      else if (run_q != RCT_CUT)             run_d = run_q + 8'd1;
      prev_d = bit_in;

      if (idx_q == 13'd0 || idx_q == APT_WIN) begin
        ref_d   = bit_in;
        match_d = 13'd1;
        idx_d   = 13'd1;
      end else begin
        idx_d = idx_q + 13'd1;
        if (bit_in == ref_q) match_d = match_q + 13'd1;
      end

      if (run_d == RCT_CUT)   rct_d = 1'b1;
      if (match_d == APT_CUT) apt_d = 1'b1;
      fail_now = (run_d == RCT_CUT) || (match_d == APT_CUT);

      case (state_q)
        ST_STARTUP: begin
          if (fail_now) state_d = ST_FAIL;
          else begin
            su_cnt_d = su_cnt_q + 16'd1;
            if (su_cnt_d == SU_BITS) begin
              state_d  = ST_RUN;
              done_d   = 1'b1;
              sh_d     = 7'd0;
              pk_cnt_d = 3'd0;
            end
          end
        end
        ST_RUN: begin
          if (fail_now) state_d = ST_FAIL;
          else begin
            sh_d     = full_byte[6:0];
            pk_cnt_d = pk_cnt_q + 3'd1;
            if (pk_cnt_q == 3'd7) begin
              sh_d = 7'd0;
              if (!valid_q || byte_ready) begin
                byte_d  = full_byte;
                valid_d = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end

    // A failure discards any held byte and the partial packer
    if (state_d == ST_FAIL) begin
      valid_d  = 1'b0;
      sh_d     = 7'd0;
      pk_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_STARTUP;
      prev_q   <= 1'b0;
      run_q    <= 8'd0;
      ref_q    <= 1'b0;
      match_q  <= 13'd0;
      idx_q    <= 13'd0;
      su_cnt_q <= 16'd0;
      sh_q     <= 7'd0;
      pk_cnt_q <= 3'd0;
      byte_q   <= 8'd0;
      valid_q  <= 1'b0;
      rct_q    <= 1'b0;
      apt_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      idx_q    <= idx_d;
      su_cnt_q <= su_cnt_d;
      sh_q     <= sh_d;
      pk_cnt_q <= pk_cnt_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      rct_q    <= rct_d;
      apt_q    <= apt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign byte_out     = byte_q;
  assign byte_valid   = valid_q;
  assign rct_fail     = rct_q;
  assign apt_fail     = apt_q;
  assign overflow     = ovf_q;
  assign startup_done = done_q;

endmodule
